qdiv: RTL and testbench
=======================

# qdiv

Sequential signed fixed-point divider: the inverse operation to the Booth multiplier in the arithmetic datapath. Accepts a 32-bit signed dividend (the sign-extended product format) and an N-bit signed divisor, runs a radix-2 restoring division on magnitudes, and returns a 32-bit quotient and an N-bit remainder. It uses the same `ce` / `input_vld` / `*_end` / `*_vld` handshake as the multiplier, so rescaling stages can chain a multiply and a divide directly.

## Interface
- `N`, default 8: divisor and remainder width, 2..31.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset. Synchronous, active-low.
- `ce`  in  1  clock enable. Gates acceptance and every iteration.
- `input_vld`  in  1  operands valid.
- `dividend_din`  in  32  signed dividend.
- `divisor_din`  in  N  signed divisor.
- `quotient_dout`  out  32  signed quotient, registered.
- `remainder_dout`  out  N  signed remainder, registered. Present only with `QDIV_REM_EN`.
- `quotient_dout_vld`  out  1  one-cycle result strobe.
- `div_end`  out  1  idle / ready. Goes low while busy.
- `div_zero`  out  1  divisor was zero. Valid with the strobe.
- `div_ovf`  out  1  quotient overflow (-2^31 / -1). Valid with the strobe.

## Operation
- States:
  - IDLE: `div_end`=1.
  - CALC: 32 iterations.
  - FIX: sign correction and output load.
- IDLE -> CALC when `ce && input_vld && div_end`. Capture the following:
  - magnitude of the dividend (32-bit unsigned)
  - magnitude of the divisor (N-bit unsigned)
  - sign of the quotient: dividend sign XOR divisor sign
  - sign of the remainder: dividend sign
  - zero and overflow conditions
- Capture also clears the iteration counter (6 bits) and the partial remainder (N+1 bits). It drives `div_end`=0 and `quotient_dout_vld`=0.
- CALC, each `ce`=1 cycle, one restoring iteration:
  - shift {partial remainder, dividend magnitude} left by 1
  - trial = partial remainder - |divisor|
  - if trial is non-negative, keep trial and shift in quotient bit 1; otherwise shift in 0
  - after iteration 32, go to FIX
- FIX (`ce`=1), results:
  - quotient = quotient sign ? -q : q, truncated toward zero
  - remainder = remainder sign ? -r : r, so it carries the dividend's sign (C semantics)
- FIX also sets `quotient_dout_vld`=1, `div_end`=1 and the flags, then returns to IDLE.
- Divide by zero (`divisor_din`==0):
  - latency is unchanged
  - quotient = 0x7FFFFFFF if the dividend is >= 0, else 0x80000000
  - remainder = 0
  - `div_zero`=1
- Overflow (dividend = 0x80000000, divisor = -1):
  - quotient = 0x7FFFFFFF
  - remainder = 0
  - `div_ovf`=1
- Divisor = -2^(N-1): its magnitude 2^(N-1) fits in N unsigned bits, so the result is handled normally.
- The outputs and flags hold their values until the next FIX or reset. They are not cleared on acceptance; only `quotient_dout_vld` drops.

## Timing
- Reset values:
  - `quotient_dout`=0
  - `remainder_dout`=0
  - `quotient_dout_vld`=0
  - `div_end`=1
  - `div_zero`=0
  - `div_ovf`=0
  - state IDLE
- Latency: the strobe rises 34 `ce`-high edges after the accepting edge (32 CALC + 1 FIX + 1 accept). With `ce` held high, the strobe is high in cycle 34 after the accept cycle.
- `ce`=0 in CALC or FIX freezes all state and outputs.
- `quotient_dout_vld` is high for exactly one cycle, the first cycle `div_end`=1.
- Back-to-back: an operation may be accepted in the strobe cycle. On that edge the strobe falls and the new operation starts, so there is no bubble.
- `input_vld` while busy is ignored, not queued. Throughput is 1 operation per 34 cycles.
- Reset mid-operation aborts immediately and outputs take their reset values. A strobe is never produced for the aborted operation.

## Configuration
- `QDIV_REM_EN` defined: the `remainder_dout` port and its sign-correction logic exist.
- `QDIV_REM_EN` undefined:
  - the port and the remainder output register are removed
  - the partial-remainder register is still needed internally
  - quotient, flags and timing are identical

## Structure
- Package `qdiv_pkg`:
  - state enum (IDLE, CALC, FIX)
  - constants `QDIV_DW`=32, `QDIV_ITER`=32
  - saturation constants `QDIV_QMAX`=0x7FFFFFFF, `QDIV_QMIN`=0x80000000
- One combinational sub-module, `qdiv_step`. It performs one restoring iteration:
  - inputs: partial remainder, dividend MSB, divisor magnitude
  - outputs: next partial remainder, quotient bit
- `qdiv_step` is unit-testable on its own.

## Test plan
- N=8, 100 / 7 -> quotient 14, remainder 2, strobe at cycle 34, flags 0.
- -100 / 7 -> quotient 0xFFFFFFF2, remainder 0xFE. 100 / -7 -> quotient 0xFFFFFFF2, remainder 0x02.
- 1000 / -128 -> quotient 0xFFFFFFF9, remainder 104.
- 5 / 0 -> quotient 0x7FFFFFFF, `div_zero`=1. -5 / 0 -> quotient 0x80000000. 0x80000000 / -1 -> quotient 0x7FFFFFFF, `div_ovf`=1.
- Back-to-back 100/7 then 50/5, accepted in the strobe cycle -> second strobe 34 cycles later with quotient 10. `input_vld` pulses while busy are ignored.
- `ce` low for 5 cycles mid-CALC -> strobe at cycle 39. `rst_n` low at cycle 10 -> no strobe, `div_end`=1, outputs 0.

Source files
------------

// File: rtl/qdiv_pkg.sv
// -----------------------------------------------------------------------------
// qdiv_pkg
// Shared types and constants for the qdiv sequential signed divider.
//   qdiv_state_e : controller states (IDLE / CALC / FIX)
//   QDIV_DW      : dividend / quotient width
//   QDIV_ITER    : restoring iterations per operation
//   QDIV_QMAX    : positive quotient saturation value
//   QDIV_QMIN    : negative quotient saturation value
// -----------------------------------------------------------------------------
package qdiv_pkg;

    localparam int QDIV_DW   = 32;
    localparam int QDIV_ITER = 32;

    localparam logic [QDIV_DW-1:0] QDIV_QMAX = 32'h7FFF_FFFF;
    localparam logic [QDIV_DW-1:0] QDIV_QMIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } qdiv_state_e;

endpackage : qdiv_pkg

// File: rtl/qdiv_step.sv
// -----------------------------------------------------------------------------
// qdiv_step
// One radix-2 restoring division iteration, purely combinational.
// Ports:
//   rem_in   [N:0]   partial remainder before the shift
//   dvd_msb          dividend-magnitude bit shifted into the remainder
//   dvs_mag  [N-1:0] divisor magnitude (unsigned)
//   rem_out  [N:0]   partial remainder after the iteration
//   q_bit            quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module qdiv_step #(
    parameter int N = 8
) (
    input  logic [N:0]   rem_in,
    input  logic         dvd_msb,
    input  logic [N-1:0] dvs_mag,
    output logic [N:0]   rem_out,
    output logic         q_bit
);

    logic [N+1:0] shifted;
    logic [N+1:0] trial;

    // The partial remainder stays below the divisor magnitude (< 2^N), so
    // after the shift it fits in N+1 bits; one extra bit carries the sign of
    // the trial subtraction.
    always_comb begin
        shifted = {rem_in, dvd_msb};
        trial   = shifted - {2'b00, dvs_mag};
        q_bit   = ~trial[N+1];
        rem_out = q_bit ? trial[N:0] : shifted[N:0];
    end

endmodule : qdiv_step

// File: rtl/qdiv.sv
// -----------------------------------------------------------------------------
// qdiv
// Sequential signed divider: 32-bit signed dividend / N-bit signed divisor,
// restoring division on magnitudes, one iteration per ce-high cycle.
// Quotient truncates toward zero; remainder carries the dividend's sign.
// Optional feature macro: QDIV_REM_EN adds the remainder_dout port and its
// sign-correction logic.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   ce                  clock enable for acceptance and every iteration
//   input_vld           operands valid
//   dividend_din [31:0] signed dividend
//   divisor_din  [N-1:0] signed divisor
//   quotient_dout [31:0] signed quotient (registered)
//   remainder_dout [N-1:0] signed remainder (registered, QDIV_REM_EN only)
//   quotient_dout_vld   one-cycle result strobe
//   div_end             idle / ready
//   div_zero            divisor was zero (valid with the strobe)
//   div_ovf             -2^31 / -1 overflow (valid with the strobe)
// -----------------------------------------------------------------------------
module qdiv
    import qdiv_pkg::*;
#(
    parameter int N = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce,
    input  logic               input_vld,
    input  logic [QDIV_DW-1:0] dividend_din,
    input  logic [N-1:0]       divisor_din,
    output logic [QDIV_DW-1:0] quotient_dout,
`ifdef QDIV_REM_EN
    output logic [N-1:0]       remainder_dout,
`endif
    output logic               quotient_dout_vld,
    output logic               div_end,
    output logic               div_zero,
    output logic               div_ovf
);

    localparam logic [5:0] ITER_LAST = 6'(QDIV_ITER - 1);

    qdiv_state_e        state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [N:0]         prem_q, prem_d;     // partial remainder
    logic [QDIV_DW-1:0] dvd_q, dvd_d;       // dividend magnitude, becomes quotient magnitude
    logic [N-1:0]       dvs_q, dvs_d;       // divisor magnitude
    logic               q_sign_q, q_sign_d;
    logic               r_sign_q, r_sign_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;

    logic [QDIV_DW-1:0] quot_q, quot_d;
    logic               vld_q, vld_d;
    logic               dz_q, dz_d;
    logic               dov_q, dov_d;
`ifdef QDIV_REM_EN
    logic [N-1:0]       rem_q, rem_d;
`endif

    logic [N:0]         step_rem;
    logic               step_qbit;

    qdiv_step #(.N(N)) u_step (
        .rem_in  (prem_q),
        .dvd_msb (dvd_q[QDIV_DW-1]),
        .dvs_mag (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_qbit)
    );

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            prem_q   <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            q_sign_q <= 1'b0;
            r_sign_q <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            quot_q   <= '0;
            vld_q    <= 1'b0;
            dz_q     <= 1'b0;
            dov_q    <= 1'b0;
`ifdef QDIV_REM_EN
            rem_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prem_q   <= prem_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            q_sign_q <= q_sign_d;
            r_sign_q <= r_sign_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            quot_q   <= quot_d;
            vld_q    <= vld_d;
            dz_q     <= dz_d;
            dov_q    <= dov_d;
`ifdef QDIV_REM_EN
            rem_q    <= rem_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        prem_d   = prem_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        q_sign_d = q_sign_q;
        r_sign_d = r_sign_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        quot_d   = quot_q;
        dz_d     = dz_q;
        dov_d    = dov_q;
        // Strobe lasts one cycle whatever ce does afterwards.
        vld_d    = 1'b0;
`ifdef QDIV_REM_EN
        rem_d    = rem_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (ce && input_vld) begin
                    // -2^31 negates to itself, which is its correct unsigned magnitude.
                    dvd_d    = dividend_din[QDIV_DW-1] ? -dividend_din : dividend_din;
                    dvs_d    = divisor_din[N-1] ? -divisor_din : divisor_din;
                    q_sign_d = dividend_din[QDIV_DW-1] ^ divisor_din[N-1];
                    r_sign_d = dividend_din[QDIV_DW-1];
                    zero_d   = (divisor_din == '0);
                    ovf_d    = (dividend_din == QDIV_QMIN) && (divisor_din == {N{1'b1}});
                    cnt_d    = '0;
                    prem_d   = '0;
                    state_d  = ST_CALC;
                end
            end

            ST_CALC: begin
                if (ce) begin
                    prem_d = step_rem;
                    dvd_d  = {dvd_q[QDIV_DW-2:0], step_qbit};
                    cnt_d  = cnt_q + 6'd1;
                    if (cnt_q == ITER_LAST) begin
                        state_d = ST_FIX;
                    end
                end
            end

            ST_FIX: begin
                if (ce) begin
                    if (zero_q) begin
                        quot_d = r_sign_q ? QDIV_QMIN : QDIV_QMAX;
                    end else if (ovf_q) begin
                        quot_d = QDIV_QMAX;
                    end else begin
                        quot_d = q_sign_q ? -dvd_q : dvd_q;
                    end
`ifdef QDIV_REM_EN
                    if (zero_q || ovf_q) begin
                        rem_d = '0;
                    end else begin
                        rem_d = r_sign_q ? -prem_q[N-1:0] : prem_q[N-1:0];
                    end
`endif
                    dz_d    = zero_q;
                    dov_d   = ovf_q;
                    vld_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        quotient_dout     = quot_q;
        quotient_dout_vld = vld_q;
        div_end           = (state_q == ST_IDLE);
        div_zero          = dz_q;
        div_ovf           = dov_q;
`ifdef QDIV_REM_EN
        remainder_dout    = rem_q;
`endif
    end

endmodule : qdiv

// File: tb/tb_qdiv.sv
// -----------------------------------------------------------------------------
// tb_qdiv
// Directed self-checking bench for qdiv (N = 8). Remainder checks are active
// when QDIV_REM_EN is defined.
// -----------------------------------------------------------------------------
module tb_qdiv;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ce;
    logic         input_vld;
    logic [31:0]  dividend_din;
    logic [N-1:0] divisor_din;
    logic [31:0]  quotient_dout;
`ifdef QDIV_REM_EN
    logic [N-1:0] remainder_dout;
`endif
    logic         quotient_dout_vld;
    logic         div_end;
    logic         div_zero;
    logic         div_ovf;

    int checks = 0;
    int errors = 0;

    logic [31:0] prev_q;
    logic        prev_z;
    logic        prev_o;

    always #5 clk = ~clk;

    qdiv #(.N(N)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ce                (ce),
        .input_vld         (input_vld),
        .dividend_din      (dividend_din),
        .divisor_din       (divisor_din),
        .quotient_dout     (quotient_dout),
`ifdef QDIV_REM_EN
        .remainder_dout    (remainder_dout),
`endif
        .quotient_dout_vld (quotient_dout_vld),
        .div_end           (div_end),
        .div_zero          (div_zero),
        .div_ovf           (div_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge with div_end high. Drives one operation, waits for
    // the strobe (bounded) and checks latency, results and flags.
    task automatic run_op(input string tag, input logic [31:0] dd, input logic [N-1:0] ds,
                          input logic [31:0] exp_q, input logic [N-1:0] exp_r,
                          input logic exp_z, input logic exp_o,
                          input int exp_lat, input int gap_at, input bit pulse);
        int cyc;
        cyc = 0;
        check({tag, "_ready"}, 32'(div_end), 32'd1);
        dividend_din = dd;
        divisor_din  = ds;
        input_vld    = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                input_vld = 1'b0;
                check({tag, "_busy"}, 32'(div_end), 32'd0);
                check({tag, "_vld_drop"}, 32'(quotient_dout_vld), 32'd0);
                check({tag, "_q_hold"}, quotient_dout, prev_q);
                check({tag, "_flags_hold"}, {30'd0, div_zero, div_ovf}, {30'd0, prev_z, prev_o});
            end
            if (pulse && cyc == 5) begin
                dividend_din = 32'h1234_5678;
                divisor_din  = N'(3);
                input_vld    = 1'b1;
            end
            if (pulse && cyc == 6) input_vld = 1'b0;
            if (gap_at != 0 && cyc == gap_at) ce = 1'b0;
            if (gap_at != 0 && cyc == gap_at + 5) ce = 1'b1;
        end while (!quotient_dout_vld && cyc < 100);
        ce = 1'b1;
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_quot"}, quotient_dout, exp_q);
        check({tag, "_flags"}, {30'd0, div_zero, div_ovf}, {30'd0, exp_z, exp_o});
        check({tag, "_end"}, 32'(div_end), 32'd1);
`ifdef QDIV_REM_EN
        check({tag, "_rem"}, 32'(remainder_dout), 32'(exp_r));
`endif
        prev_q = exp_q;
        prev_z = exp_z;
        prev_o = exp_o;
    endtask

    task automatic reset_abort();
        int cyc;
        int strobes;
        strobes      = 0;
        dividend_din = 32'd100;
        divisor_din  = N'(7);
        input_vld    = 1'b1;
        for (cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (cyc == 1) input_vld = 1'b0;
            if (quotient_dout_vld) strobes++;
            if (cyc == 10) rst_n = 1'b0;
            if (cyc == 11) begin
                check("rst_abort_end", 32'(div_end), 32'd1);
                check("rst_abort_quot", quotient_dout, 32'd0);
                check("rst_abort_flags", {30'd0, div_zero, div_ovf}, 32'd0);
`ifdef QDIV_REM_EN
                check("rst_abort_rem", 32'(remainder_dout), 32'd0);
`endif
                rst_n = 1'b1;
            end
        end
        check("rst_abort_no_strobe", 32'(strobes), 32'd0);
        check("rst_abort_idle", 32'(div_end), 32'd1);
    endtask

    initial begin
        rst_n        = 1'b0;
        ce           = 1'b1;
        input_vld    = 1'b0;
        dividend_din = '0;
        divisor_din  = '0;
        prev_q       = '0;
        prev_z       = 1'b0;
        prev_o       = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_quot", quotient_dout, 32'd0);
        check("reset_vld", 32'(quotient_dout_vld), 32'd0);
        check("reset_end", 32'(div_end), 32'd1);
        check("reset_flags", {30'd0, div_zero, div_ovf}, 32'd0);
`ifdef QDIV_REM_EN
        check("reset_rem", 32'(remainder_dout), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Each op after the first is accepted in the previous strobe cycle.
        run_op("p100_p7",   32'd100,       8'd7,   32'd14,        8'd2,   1'b0, 1'b0, 34, 0, 1'b0);
        run_op("b2b_50_5",  32'd50,        8'd5,   32'd10,        8'd0,   1'b0, 1'b0, 34, 0, 1'b0);
        run_op("n100_p7",   32'hFFFF_FF9C, 8'd7,   32'hFFFF_FFF2, 8'hFE,  1'b0, 1'b0, 34, 0, 1'b0);
        run_op("p100_n7",   32'd100,       8'hF9,  32'hFFFF_FFF2, 8'h02,  1'b0, 1'b0, 34, 0, 1'b0);
        run_op("p1000_n128",32'd1000,      8'h80,  32'hFFFF_FFF9, 8'd104, 1'b0, 1'b0, 34, 0, 1'b0);
        run_op("n7_n2",     32'hFFFF_FFF9, 8'hFE,  32'd3,         8'hFF,  1'b0, 1'b0, 34, 0, 1'b0);
        run_op("min_p1",    32'h8000_0000, 8'd1,   32'h8000_0000, 8'd0,   1'b0, 1'b0, 34, 0, 1'b0);
        run_op("p5_zero",   32'd5,         8'd0,   32'h7FFF_FFFF, 8'd0,   1'b1, 1'b0, 34, 0, 1'b0);
        run_op("n5_zero",   32'hFFFF_FFFB, 8'd0,   32'h8000_0000, 8'd0,   1'b1, 1'b0, 34, 0, 1'b0);
        run_op("min_n1_ovf",32'h8000_0000, 8'hFF,  32'h7FFF_FFFF, 8'd0,   1'b0, 1'b1, 34, 0, 1'b0);
        run_op("ce_gap",    32'd100,       8'd7,   32'd14,        8'd2,   1'b0, 1'b0, 39, 10, 1'b1);

        @(negedge clk);
        check("strobe_one_cycle", 32'(quotient_dout_vld), 32'd0);
        check("idle_after_strobe", 32'(div_end), 32'd1);
        check("quot_hold_idle", quotient_dout, 32'd14);

        reset_abort();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_qdiv
